// File: rtl/cfu_types.sv
// Shared CFU request types: the packed request word pushed into the request FIFO.
// Combinational definitions only; no latency or backpressure of its own.
package cfu_types;

    localparam int CFU_ID_WIDTH = 3;
    localparam int CFU_XLEN     = 32;

    typedef struct packed {
        logic [CFU_ID_WIDTH-1:0] id;
        logic [6:0]              funct7;
        logic [2:0]              funct3;
        logic [CFU_XLEN-1:0]     rs1;
        logic [CFU_XLEN-1:0]     rs2;
    } cfu_request_t;

    localparam int CFU_REQ_W = $bits(cfu_request_t);

    // Holding-stage state; the encoding doubles as held_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } issue_state_t;

endpackage

// File: rtl/cfu_fifo_interface.sv
// Push side of the CFU request FIFO: master writes requests, slave reports full/pop.
// Pure wiring; backpressure is carried by full, relieved by a same-cycle pop.
interface cfu_fifo_interface;
    import cfu_types::*;

    logic                 push;
    logic                 potential_push;
    logic [CFU_REQ_W-1:0] data_in;
    logic                 full;
    logic                 pop;

    modport master (output push, output potential_push, output data_in,
                    input  full, input  pop);
    modport slave  (input  push, input  potential_push, input  data_in,
                    output full, output pop);

endinterface

// File: rtl/cfu_credit_counter.sv
// Up/down credit counter with full flag; inc, dec and cancel may coincide.
// Count updates one cycle after the strobes; full never stalls the counter itself.
module cfu_credit_counter #(
    parameter  int MAX_COUNT = 4,
    localparam int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          cancel,
    output logic [CW-1:0] count,
    output logic          full
);

    localparam int          CW1   = CW + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

    assign full = (count == MAX_C);

    // Sum in one extra bit so a transient negative term cannot wrap early.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= CW'({1'b0, count} + CW1'(inc) - CW1'(dec) - CW1'(cancel));
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(dec && (count == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(inc && !dec && full));

endmodule

// File: rtl/cfu_request_issue.sv
// Tags CFU instructions with a rolling ID and holds one request for the request FIFO.
// Push 1 cycle after accept; stalls while FIFO full without pop, or while credits are exhausted.
module cfu_request_issue
    import cfu_types::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int ID_WIDTH        = CFU_ID_WIDTH,
    parameter  int XLEN            = CFU_XLEN,
    localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [2:0]          issue_funct3,
    input  logic [6:0]          issue_funct7,
    input  logic [XLEN-1:0]     issue_rs1,
    input  logic [XLEN-1:0]     issue_rs2,
    output logic [ID_WIDTH-1:0] issue_id,
    cfu_fifo_interface.master   fifo,
    input  logic                resp_done,
    input  logic                flush,
    output logic [OW-1:0]       outstanding
);

    if (MAX_OUTSTANDING < 1) begin : g_bad_max
        $error("MAX_OUTSTANDING must be at least 1");
    end
    if ((2 ** ID_WIDTH) < MAX_OUTSTANDING) begin : g_bad_id
        $error("ID space smaller than MAX_OUTSTANDING; IDs would alias in flight");
    end
    if ((ID_WIDTH != CFU_ID_WIDTH) || (XLEN != CFU_XLEN)) begin : g_bad_width
        $error("ID_WIDTH/XLEN must match the cfu_request_t field widths");
    end

    issue_state_t        state, state_next;
    cfu_request_t        held_req;
    logic [ID_WIDTH-1:0] next_id;
    logic                held_valid;
    logic                drain;
    logic                credit_full;
    logic                credit_ok;
    logic                accept;
    logic                cancel;

    assign held_valid = (state == ST_HELD);
    // A pop frees a slot this cycle, so a full FIFO can still take the push.
    assign drain      = held_valid & (~fifo.full | fifo.pop);
    assign credit_ok  = ~credit_full | resp_done;
    assign issue_ready = rst & ~flush & credit_ok & (~held_valid | drain);
    assign accept     = issue_valid & issue_ready;
    // A flushed request that already drained is in the FIFO; it keeps its credit.
    assign cancel     = flush & held_valid & ~drain;

    assign issue_id            = next_id;
    assign fifo.push           = drain;
    assign fifo.potential_push = drain;
    assign fifo.data_in        = held_req;

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (accept) state_next = ST_HELD;
            ST_HELD:  if (!accept && (drain || flush)) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_req <= '0;
            next_id  <= '0;
        end else if (accept) begin
            held_req <= '{id: next_id, funct7: issue_funct7, funct3: issue_funct3,
                          rs1: issue_rs1, rs2: issue_rs2};
            next_id  <= next_id + ID_WIDTH'(1);
        end
    end

    cfu_credit_counter #(.MAX_COUNT(MAX_OUTSTANDING)) u_credits (
        .clk    (clk),
        .rst    (rst),
        .inc    (accept),
        .dec    (resp_done),
        .cancel (cancel),
        .count  (outstanding),
        .full   (credit_full)
    );

    a_no_overflow_push: assert property (@(posedge clk) disable iff (!rst)
        !(fifo.push && fifo.full && !fifo.pop));

endmodule
